// File: rtl/unsigned_seq_divider_16by8.sv
// unsigned_seq_divider_16by8
//   Iterative restoring divider for unsigned operands. Divides a DW-bit
//   dividend z by a VW-bit divisor y, one quotient bit per clock, giving
//   quotient q and remainder r with z == q*y + r. Latency is a fixed DW
//   cycles from the accepting edge to out_valid. A zero divisor finishes in
//   one cycle with q all-ones, r zero and div_by_zero set.
//
// Ports
//   clk          in   1    clock, rising edge
//   rst_n        in   1    synchronous active-low reset
//   in_valid     in   1    operand pair valid
//   in_ready     out  1    divider can accept operands (IDLE and not in reset)
//   z            in   DW   dividend
//   y            in   VW   divisor
//   out_valid    out  1    result valid
//   out_ready    in   1    consumer accepts result
//   q            out  DW   quotient
//   r            out  VW   remainder
//   div_by_zero  out  1    result produced from y == 0
//   busy         out  1    an operation is in flight or awaiting handshake
module unsigned_seq_divider_16by8 #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [VW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          div_by_zero,
  output logic          busy
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] qreg;
  logic [VW:0]   rem;
  logic [VW-1:0] divisor;
  logic [CW-1:0] cnt;

  logic [VW:0]   t;
  logic [VW:0]   diff;
  logic          take;
  logic          last;
  logic [DW-1:0] qreg_nxt;
  logic [VW:0]   rem_nxt;
  logic          accept;
  logic          release_res;

  assign in_ready    = (state == IDLE) & rst_n;
  assign busy        = (state != IDLE);
  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;

  // One restoring step. t can reach 2*divisor-1, hence the VW+1-bit
  // partial remainder. rem[VW] is always clear after a step; folding it into
  // take keeps the comparison correct for the full register width.
  always_comb begin
    t        = {rem[VW-1:0], qreg[DW-1]};
    diff     = t - {1'b0, divisor};
    take     = rem[VW] | (t >= {1'b0, divisor});
    rem_nxt  = take ? diff : t;
    qreg_nxt = {qreg[DW-2:0], take};
    last     = (cnt == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (y == '0) ? DONE : RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qreg        <= '0;
      rem         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (y == '0) begin
              q           <= '1;
              r           <= '0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              qreg        <= z;
              rem         <= '0;
              divisor     <= y;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          qreg <= qreg_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            q         <= qreg_nxt;
            r         <= rem_nxt[VW-1:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// tb_unsigned_seq_divider_16by8
//   Directed and random checks of the 16-by-8 sequential divider against
//   plain integer division.
module tb_unsigned_seq_divider_16by8;

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] z;
  logic [VW-1:0] y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          div_by_zero;
  logic          busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [DW-1:0] exp_q;
  logic [VW-1:0] exp_r;
  logic          exp_d;

  unsigned_seq_divider_16by8 #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z           (z),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference result from integer division.
  task automatic set_expected(input logic [DW-1:0] zz, input logic [VW-1:0] yy);
    if (yy == '0) begin
      exp_q = '1;
      exp_r = '0;
      exp_d = 1'b1;
    end else begin
      exp_q = zz / DW'(yy);
      exp_r = VW'(zz % DW'(yy));
      exp_d = 1'b0;
    end
  endtask

  // Called at the negedge just after the accepting edge; counts further
  // rising edges until out_valid is seen, bounded.
  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_r"}, 32'(r), 32'(exp_r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_d));
  endtask

  // Drive an operand pair from a negedge, wait for the result, check it.
  task automatic start_and_wait(input logic [DW-1:0] zz, input logic [VW-1:0] yy, input string tag);
    int unsigned lat;
    set_expected(zz, yy);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    z = zz;
    y = yy;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, lat, (yy == '0) ? 32'd0 : 32'(DW));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    check_result(tag);
    if (yy != '0) begin
      check({tag, "_identity"}, 32'(q) * 32'(yy) + 32'(r), 32'(zz));
      check({tag, "_r_lt_y"}, 32'(r < yy), 32'd1);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_result({tag, "_held"});
  endtask

  task automatic run_op(input logic [DW-1:0] zz, input logic [VW-1:0] yy,
                        input int unsigned hold, input string tag);
    start_and_wait(zz, yy, tag);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_stall_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      check_result({tag, "_stall"});
    end
    release_result(tag);
  endtask

  initial begin
    int unsigned rises;
    logic [DW-1:0] rz;
    logic [VW-1:0] ry;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, with literal cross-checks of the quotient/remainder
    run_op(16'hABCD, 8'h12, 0, "v1");
    check("v1_lit_q", 32'(q), 32'h098B);
    check("v1_lit_r", 32'(r), 32'h07);
    run_op(16'hC418, 8'hFB, 0, "v2a");
    check("v2a_lit_q", 32'(q), 32'h00C8);
    check("v2a_lit_r", 32'(r), 32'h00);
    run_op(16'hFFFF, 8'h01, 0, "v2b");
    check("v2b_lit_q", 32'(q), 32'hFFFF);
    run_op(16'h1234, 8'h00, 2, "v3");
    check("v3_lit_q", 32'(q), 32'hFFFF);
    check("v3_lit_dbz", 32'(div_by_zero), 32'd1);
    run_op(16'h0005, 8'hC8, 0, "v4a");
    check("v4a_lit_q", 32'(q), 32'h0000);
    check("v4a_lit_r", 32'(r), 32'h05);
    run_op(16'hFFFF, 8'hFF, 0, "v4b");
    check("v4b_lit_q", 32'(q), 32'h0101);
    run_op(16'h0000, 8'h37, 0, "zero_z");

    // Back-pressure: a pending operand waits until the result handshake
    start_and_wait(16'hBEEF, 8'h07, "bp");
    z = 16'h1111;
    y = 8'h11;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_stall_ov", 32'(out_valid), 32'd1);
      check("bp_stall_in_ready", 32'(in_ready), 32'd0);
      check("bp_stall_busy", 32'(busy), 32'd1);
      check_result("bp_stall");
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_ov", 32'(out_valid), 32'd0);
    check("bp_hs_in_ready", 32'(in_ready), 32'd1);
    check_result("bp_hs_held");
    set_expected(16'h1111, 8'h11);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    wait_valid(rises);
    check("bp_second_latency", rises, 32'(DW));
    check_result("bp_second");
    release_result("bp_second");

    // Reset in the middle of RUN
    z = 16'hABCD;
    y = 8'h12;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    rises = 0;
    for (int unsigned i = 0; i < 24; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("mid_rst_no_ov", rises, 32'd0);
    run_op(16'hABCD, 8'h12, 0, "post_rst");

    // Random operand pairs, zero divisor included occasionally
    for (int unsigned n = 0; n < 2000; n++) begin
      rz = DW'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? VW'($urandom_range(0, 3)) : VW'($urandom);
      run_op(rz, ry, 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
